// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

  // Ceiling log2; sizes the iteration counter as clog2(WIDTH+1).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_twos_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x (modulo 2^N).
module twos_negate #(
  parameter int N = 8
) (
  input  logic         neg,
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);

  assign y = neg ? (~x + N'(1)) : x;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one (WIDTH+1)-bit adder reused over WIDTH
// cycles, signed operands handled as sign-magnitude around an unsigned core.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("seq_multiplier: WIDTH out of range 2..32");
    end
  endgenerate

  state_t               state_reg, state_next;
  logic [WIDTH:0]       acc_reg, acc_next;
  logic [WIDTH-1:0]     mpl_reg, mpl_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic                 neg_reg, neg_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum, step;
  logic [2*WIDTH-1:0]   raw, res;

  assign neg_a = is_signed & a[WIDTH-1];
  assign neg_b = is_signed & b[WIDTH-1];

  twos_negate #(.N(WIDTH)) u_mag_a (.neg(neg_a), .x(a), .y(a_mag));
  twos_negate #(.N(WIDTH)) u_mag_b (.neg(neg_b), .x(b), .y(b_mag));

  // Single adder; the carry lands in acc[WIDTH] before the right shift.
  assign sum  = acc_reg + {1'b0, mcand_reg};
  assign step = mpl_reg[0] ? sum : acc_reg;
  // Low 2W bits of the pair after this cycle's shift, used on the final step.
  assign raw  = {step, mpl_reg[WIDTH-1:1]};

  twos_negate #(.N(2*WIDTH)) u_res (.neg(neg_reg), .x(raw), .y(res));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mpl_reg     <= '0;
      mcand_reg   <= '0;
      neg_reg     <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mpl_reg     <= mpl_next;
      mcand_reg   <= mcand_next;
      neg_reg     <= neg_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next     = acc_reg;
    mpl_next     = mpl_reg;
    mcand_next   = mcand_reg;
    neg_next     = neg_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next   = '0;
          mpl_next   = b_mag;
          mcand_next = a_mag;
          neg_next   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_next   = '0;
        end
      end
      RUN: begin
        acc_next = {1'b0, step[WIDTH:1]};
        mpl_next = {step[0], mpl_reg[WIDTH-1:1]};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) product_next = res;
      end
      default: ;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule
